dmem_arb: RTL and testbench
===========================

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter RD_LAT, default 1, memory data-port read latency in cycles; legal 1..4.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ren_1, ren_2  in  1  per-core data read request.
REQ-005 raddr_1, raddr_2  in  [15:1]  per-core read word address.
REQ-006 wen_1, wen_2  in  1  per-core write request.
REQ-007 waddr_1, waddr_2  in  [15:1]  per-core write word address.
REQ-008 wdata_1, wdata_2  in  16  per-core write data.
REQ-009 stall_1, stall_2  out  1  request not accepted this cycle; core holds request unchanged.
REQ-010 rvalid_1, rvalid_2  out  1  read data returned this cycle.
REQ-011 rdata_1, rdata_2  out  16  returned read data.
REQ-012 m_raddr  out  [15:1]  shared memory read port address.
REQ-013 m_rdata  in  16  shared memory read data, valid RD_LAT cycles after m_raddr.
REQ-014 m_wen, m_waddr [15:1], m_wdata [15:0]  out  shared memory write port.

Function
REQ-015 A core requests when ren_c|wen_c; conflict when both cores assert ren, or both assert wen.
REQ-016 No conflict: both cores granted same cycle, stall_1=stall_2=0.
REQ-017 Conflict: only the core named by priority pointer granted (read and write together); other core's stall=1, combinational same cycle.
REQ-018 Priority pointer toggles to the losing core after every conflict cycle; unchanged otherwise; guarantees loser granted next cycle.
REQ-019 A core is never partially granted; its read and write are accepted in the same cycle or both stalled.
REQ-020 m_raddr = granted reader's raddr, 0 when no read granted; m_wen=1 only when a write granted, m_waddr/m_wdata = granted writer's values, 0 otherwise.
REQ-021 Each granted read enters an RD_LAT-deep tag pipe (valid, core id); on exit, that core's rvalid=1 for exactly one cycle and rdata=m_rdata.
REQ-022 rdata_c holds its last returned value when rvalid_c=0.
REQ-023 Back-to-back reads accepted every cycle; throughput one read and one write per cycle total.
REQ-024 Requesting core with neither ren nor wen: stall=0.
REQ-025 Pointer wrap: single bit, 1 -> 2 -> 1.

Reset
REQ-026 While reset=1: stall_1=stall_2=1, m_wen=0, m_raddr=0, m_waddr=0, m_wdata=0, no grants.
REQ-027 After reset: pointer=core 1, tag pipe empty, rvalid_1=rvalid_2=0, rdata_1=rdata_2=0.
REQ-028 Reset mid-operation discards in-flight reads; no rvalid for them after reset deasserts.
REQ-029 First cycle with reset=0 arbitrates normally.

Configuration
REQ-030 Macro DMEM_ARB_FWD_EN defined: granted read and granted write in the same cycle to the same word address return the write's wdata (carried in tag pipe) instead of m_rdata.
REQ-031 DMEM_ARB_FWD_EN undefined: all returned data is m_rdata; no forwarding logic present.

Verification
REQ-032 Reset, then core1 ren raddr=0x0010 alone (RD_LAT=1) -> stall_1=0, m_raddr=0x0010, next cycle rvalid_1=1, rdata_1=m_rdata.
REQ-033 Both ren (0x0020, 0x0030) for 2 cycles after reset -> cycle0 core1 granted, stall_2=1; cycle1 core2 granted, m_raddr=0x0030, stall_1=1 if core1 still reading.
REQ-034 core1 wen waddr=0x0040 wdata=0xBEEF, core2 ren 0x0050 same cycle -> both granted, m_wen=1, m_raddr=0x0050, no stall.
REQ-035 FWD_EN defined, core1 wen 0x0060 data 0x1234, core2 ren 0x0060 same cycle -> rdata_2=0x1234 with rvalid_2; undefined -> rdata_2=m_rdata.
REQ-036 RD_LAT=3, reads issued, reset asserted 1 cycle later -> no rvalid ever for those reads, stalls=1 during reset.
REQ-037 Sustained both-write conflict 8 cycles -> grants alternate 1,2,1,2...; each core 4 m_wen cycles.

Source files
------------

// File: rtl/dmem_arb_if.sv
// Two-core data memory arbiter bundle: core request/return ports
// plus the shared single-read/single-write memory port.
interface dmem_arb_if;
    logic        ren_1;
    logic        ren_2;
    logic [15:1] raddr_1;
    logic [15:1] raddr_2;
    logic        wen_1;
    logic        wen_2;
    logic [15:1] waddr_1;
    logic [15:1] waddr_2;
    logic [15:0] wdata_1;
    logic [15:0] wdata_2;
    logic        stall_1;
    logic        stall_2;
    logic        rvalid_1;
    logic        rvalid_2;
    logic [15:0] rdata_1;
    logic [15:0] rdata_2;
    logic [15:1] m_raddr;
    logic [15:0] m_rdata;
    logic        m_wen;
    logic [15:1] m_waddr;
    logic [15:0] m_wdata;

    modport slave (
        input  ren_1, ren_2, raddr_1, raddr_2,
        input  wen_1, wen_2, waddr_1, waddr_2,
        input  wdata_1, wdata_2, m_rdata,
        output stall_1, stall_2, rvalid_1, rvalid_2,
        output rdata_1, rdata_2,
        output m_raddr, m_wen, m_waddr, m_wdata
    );

    modport master (
        output ren_1, ren_2, raddr_1, raddr_2,
        output wen_1, wen_2, waddr_1, waddr_2,
        output wdata_1, wdata_2, m_rdata,
        input  stall_1, stall_2, rvalid_1, rvalid_2,
        input  rdata_1, rdata_2,
        input  m_raddr, m_wen, m_waddr, m_wdata
    );
endinterface

// File: rtl/dmem_arb.sv
// Two-core data memory arbiter with round-robin conflict resolution.
// Define DMEM_ARB_FWD_EN to forward same-cycle write data to a matching read.
module dmem_arb #(
    parameter int RD_LAT = 1
) (
    input logic       clk,
    input logic       reset,
    dmem_arb_if.slave bus
);
    localparam int LAST = RD_LAT - 1;

    // ptr_q = 0 means core 1 wins the next conflict
    logic              ptr_q, ptr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] id_q, id_d;
    logic [15:0]       hold_1_q, hold_1_d;
    logic [15:0]       hold_2_q, hold_2_d;
    logic              conflict;
    logic              g_1, g_2;
    logic              rg_1, rg_2;
    logic              wg_1, wg_2;
    logic [15:0]       ret_data;
`ifdef DMEM_ARB_FWD_EN
    logic [RD_LAT-1:0] fwd_q, fwd_d;
    logic [15:0]       fdat_q [RD_LAT];
    logic [15:0]       fdat_d [RD_LAT];
`endif

    always_comb begin
        conflict    = (bus.ren_1 & bus.ren_2) |
                      (bus.wen_1 & bus.wen_2);
        bus.stall_1 = reset | (conflict & ptr_q);
        bus.stall_2 = reset | (conflict & ~ptr_q);
        g_1         = ~bus.stall_1;
        g_2         = ~bus.stall_2;
        rg_1        = g_1 & bus.ren_1;
        rg_2        = g_2 & bus.ren_2;
        wg_1        = g_1 & bus.wen_1;
        wg_2        = g_2 & bus.wen_2;
        ptr_d       = conflict ? ~ptr_q : ptr_q;
    end

    always_comb begin
        bus.m_raddr = '0;
        bus.m_wen   = wg_1 | wg_2;
        bus.m_waddr = '0;
        bus.m_wdata = '0;
        if (rg_1)
            bus.m_raddr = bus.raddr_1;
        else if (rg_2)
            bus.m_raddr = bus.raddr_2;
        if (wg_1) begin
            bus.m_waddr = bus.waddr_1;
            bus.m_wdata = bus.wdata_1;
        end else if (wg_2) begin
            bus.m_waddr = bus.waddr_2;
            bus.m_wdata = bus.wdata_2;
        end
    end

    // Tag pipe: one slot per cycle of memory read latency
    always_comb begin
        vld_d[0] = rg_1 | rg_2;
        id_d[0]  = rg_2;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
`ifdef DMEM_ARB_FWD_EN
        fwd_d[0]  = (rg_1 | rg_2) & bus.m_wen &
                    (bus.m_raddr == bus.m_waddr);
        fdat_d[0] = bus.m_wdata;
        for (int i = 1; i < RD_LAT; i++) begin
            fwd_d[i]  = fwd_q[i-1];
            fdat_d[i] = fdat_q[i-1];
        end
`endif
    end

    always_comb begin
`ifdef DMEM_ARB_FWD_EN
        ret_data = fwd_q[LAST] ? fdat_q[LAST] : bus.m_rdata;
`else
        ret_data = bus.m_rdata;
`endif
        // Gate with reset so reads in flight at reset never return
        bus.rvalid_1 = ~reset & vld_q[LAST] & ~id_q[LAST];
        bus.rvalid_2 = ~reset & vld_q[LAST] & id_q[LAST];
        hold_1_d     = bus.rvalid_1 ? ret_data : hold_1_q;
        hold_2_d     = bus.rvalid_2 ? ret_data : hold_2_q;
        bus.rdata_1  = hold_1_d;
        bus.rdata_2  = hold_2_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= 1'b0;
            vld_q    <= '0;
            id_q     <= '0;
            hold_1_q <= '0;
            hold_2_q <= '0;
`ifdef DMEM_ARB_FWD_EN
            fwd_q    <= '0;
            for (int i = 0; i < RD_LAT; i++)
                fdat_q[i] <= '0;
`endif
        end else begin
            ptr_q    <= ptr_d;
            vld_q    <= vld_d;
            id_q     <= id_d;
            hold_1_q <= hold_1_d;
            hold_2_q <= hold_2_d;
`ifdef DMEM_ARB_FWD_EN
            fwd_q    <= fwd_d;
            for (int i = 0; i < RD_LAT; i++)
                fdat_q[i] <= fdat_d[i];
`endif
        end
    end
endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb: one RD_LAT=1 and one RD_LAT=3
// instance driven with the same directed request stream.
module tb_dmem_arb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ren_1, ren_2, wen_1, wen_2;
    logic [15:1] raddr_1, raddr_2, waddr_1, waddr_2;
    logic [15:0] wdata_1, wdata_2;
    logic [15:0] ma_q;
    logic [15:0] mb_q [3];
    logic [15:0] exp35, ew_1, ew_2;
    int          checks = 0;
    int          failures = 0;
    int          cnt_1, cnt_2, win;

    typedef struct {
        int          core;
        logic [15:0] data;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    dmem_arb_if ia();
    dmem_arb_if ib();

    assign ia.ren_1 = ren_1;     assign ib.ren_1 = ren_1;
    assign ia.ren_2 = ren_2;     assign ib.ren_2 = ren_2;
    assign ia.raddr_1 = raddr_1; assign ib.raddr_1 = raddr_1;
    assign ia.raddr_2 = raddr_2; assign ib.raddr_2 = raddr_2;
    assign ia.wen_1 = wen_1;     assign ib.wen_1 = wen_1;
    assign ia.wen_2 = wen_2;     assign ib.wen_2 = wen_2;
    assign ia.waddr_1 = waddr_1; assign ib.waddr_1 = waddr_1;
    assign ia.waddr_2 = waddr_2; assign ib.waddr_2 = waddr_2;
    assign ia.wdata_1 = wdata_1; assign ib.wdata_1 = wdata_1;
    assign ia.wdata_2 = wdata_2; assign ib.wdata_2 = wdata_2;
    assign ia.m_rdata = ma_q;
    assign ib.m_rdata = mb_q[2];

    dmem_arb #(.RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ia));
    dmem_arb #(.RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ib));

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:1] a);
        return {a, 1'b1} ^ 16'h5A5A;
    endfunction

    // Memory model: data for the address presented RD_LAT cycles ago
    always @(posedge clk) begin
        ma_q    <= memf(ia.m_raddr);
        mb_q[0] <= memf(ib.m_raddr);
        mb_q[1] <= mb_q[0];
        mb_q[2] <= mb_q[1];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int core, input logic [15:0] d);
        exp_t e;
        e.core = core;
        e.data = d;
        qa.push_back(e);
        qb.push_back(e);
    endtask

    task automatic pop(input bit b, input int core, input logic [15:0] d);
        exp_t e;
        string n;
        n = b ? "ret_b" : "ret_a";
        checks++;
        if ((b && qb.size() == 0) || (!b && qa.size() == 0)) begin
            failures++;
            $display("FAIL %s: got rvalid core %0d data %h expected none",
                     n, core, d);
            return;
        end
        if (b) e = qb.pop_front();
        else   e = qa.pop_front();
        if (e.core != core || e.data !== d) begin
            failures++;
            $display("FAIL %s: got core %0d data %h expected core %0d data %h",
                     n, core, d, e.core, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (ia.rvalid_1) pop(1'b0, 1, ia.rdata_1);
        if (ia.rvalid_2) pop(1'b0, 2, ia.rdata_2);
        if (ib.rvalid_1) pop(1'b1, 1, ib.rdata_1);
        if (ib.rvalid_2) pop(1'b1, 2, ib.rdata_2);
    end

    task automatic idle();
        ren_1 = 0; ren_2 = 0; wen_1 = 0; wen_2 = 0;
        raddr_1 = '0; raddr_2 = '0; waddr_1 = '0; waddr_2 = '0;
        wdata_1 = '0; wdata_2 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        step(); step();
        // Requests during reset are never granted
        ren_1 = 1; raddr_1 = 'h10;
        wen_2 = 1; waddr_2 = 'h11; wdata_2 = 16'hABCD;
        #3;
        chk("rst_stall", {ia.stall_1, ia.stall_2}, 2'b11);
        chk("rst_stall_b", {ib.stall_1, ib.stall_2}, 2'b11);
        chk("rst_m_raddr", ia.m_raddr, 0);
        chk("rst_m_wen", ia.m_wen, 0);
        chk("rst_m_waddr", ia.m_waddr, 0);
        chk("rst_m_wdata", ia.m_wdata, 0);

        step(); idle(); reset = 0; #3;
        chk("post_rvalid", {ia.rvalid_1, ia.rvalid_2}, 0);
        chk("post_rdata_1", ia.rdata_1, 0);
        chk("post_rdata_2", ia.rdata_2, 0);

        // Single read, core 1
        step(); ren_1 = 1; raddr_1 = 'h10;
        push(1, memf('h10)); #3;
        chk("rd1_stall_1", ia.stall_1, 0);
        chk("rd1_m_raddr", ia.m_raddr, 'h10);
        step(); idle(); #3;
        chk("lat1_rvalid", ia.rvalid_1, 1);
        chk("lat1_rdata", ia.rdata_1, memf('h10));

        // Read conflict: core 1 then core 2
        step(); ren_1 = 1; raddr_1 = 'h20; ren_2 = 1; raddr_2 = 'h30;
        push(1, memf('h20)); #3;
        chk("c0_stall", {ia.stall_1, ia.stall_2}, 2'b01);
        chk("c0_m_raddr", ia.m_raddr, 'h20);
        step(); raddr_1 = 'h21;
        push(2, memf('h30)); #3;
        chk("c1_stall", {ia.stall_1, ia.stall_2}, 2'b10);
        chk("c1_m_raddr", ia.m_raddr, 'h30);
        step(); ren_2 = 0;
        push(1, memf('h21)); #3;
        chk("c2_stall_1", ia.stall_1, 0);
        chk("c2_m_raddr", ia.m_raddr, 'h21);

        // Write core 1 and read core 2: no conflict
        step(); idle();
        wen_1 = 1; waddr_1 = 'h40; wdata_1 = 16'hBEEF;
        ren_2 = 1; raddr_2 = 'h50;
        push(2, memf('h50)); #3;
        chk("wr_stall", {ia.stall_1, ia.stall_2}, 0);
        chk("wr_m_wen", ia.m_wen, 1);
        chk("wr_m_waddr", ia.m_waddr, 'h40);
        chk("wr_m_wdata", ia.m_wdata, 16'hBEEF);
        chk("wr_m_raddr", ia.m_raddr, 'h50);

        // Same-word write and read in one cycle
        step(); waddr_1 = 'h60; wdata_1 = 16'h1234; raddr_2 = 'h60;
`ifdef DMEM_ARB_FWD_EN
        exp35 = 16'h1234;
`else
        exp35 = memf('h60);
`endif
        push(2, exp35); #3;
        chk("fw_stall", {ia.stall_1, ia.stall_2}, 0);

        // Write conflict: core 1 wins read and write together
        step(); idle();
        ren_1 = 1; raddr_1 = 'h70;
        wen_1 = 1; waddr_1 = 'h71; wdata_1 = 16'h1111;
        wen_2 = 1; waddr_2 = 'h72; wdata_2 = 16'h2222;
        push(1, memf('h70)); #3;
        chk("pg_stall", {ia.stall_1, ia.stall_2}, 2'b01);
        chk("pg_m_raddr", ia.m_raddr, 'h70);
        chk("pg_m_waddr", ia.m_waddr, 'h71);
        chk("pg_m_wdata", ia.m_wdata, 16'h1111);
        step(); ren_1 = 0; wen_1 = 0; #3;
        chk("pg2_stall_2", ia.stall_2, 0);
        chk("pg2_m_wdata", ia.m_wdata, 16'h2222);
        chk("pg2_m_raddr", ia.m_raddr, 0);
        step(); idle(); step(); step(); step(); #3;
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        chk("hold_1", ia.rdata_1, memf('h70));
        chk("hold_2", ia.rdata_2, exp35);
        chk("hold_2b", ib.rdata_2, exp35);

        // Reads in flight when reset hits are discarded
        step(); ren_1 = 1; raddr_1 = 'h80; #3;
        chk("fl_stall_1", ia.stall_1, 0);
        step(); reset = 1; ren_1 = 0; ren_2 = 1; raddr_2 = 'h81; #3;
        chk("fl_rst_stall", {ia.stall_1, ia.stall_2}, 2'b11);
        chk("fl_rst_stall_b", {ib.stall_1, ib.stall_2}, 2'b11);
        chk("fl_rst_m_raddr", ia.m_raddr, 0);
        step(); #3;
        chk("fl_rst2_stall_b", {ib.stall_1, ib.stall_2}, 2'b11);
        step(); idle(); reset = 0;
        repeat (5) step();
        #3;
        chk("fl_rdata_1", ia.rdata_1, 0);
        chk("fl_rdata_1b", ib.rdata_1, 0);

        // Sustained write conflict alternates 1,2,1,2...
        cnt_1 = 0; cnt_2 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            ew_1 = 16'h1000 + 16'(i);
            ew_2 = 16'h2000 + 16'(i);
            wen_1 = 1; waddr_1 = 15'h100 + 15'(i); wdata_1 = ew_1;
            wen_2 = 1; waddr_2 = 15'h200 + 15'(i); wdata_2 = ew_2;
            #3;
            win = (i % 2 == 0) ? 1 : 2;
            chk("alt_stall_1", ia.stall_1, (win == 2) ? 1 : 0);
            chk("alt_m_wdata", ia.m_wdata, (win == 1) ? ew_1 : ew_2);
            if (ia.m_wen && ia.m_wdata == ew_1) cnt_1++;
            if (ia.m_wen && ia.m_wdata == ew_2) cnt_2++;
        end
        chk("alt_cnt_1", cnt_1, 4);
        chk("alt_cnt_2", cnt_2, 4);

        // Final read on the deep instance and data hold
        step(); idle(); ren_2 = 1; raddr_2 = 'h90;
        push(2, memf('h90));
        step(); idle(); step(); step(); step(); #3;
        chk("end_hold_b", ib.rdata_2, memf('h90));
        chk("end_rvalid_b", ib.rvalid_2, 0);
        chk("end_q_a", qa.size(), 0);
        chk("end_q_b", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
